// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - opcode constants, FSM states and trap causes for npc_mc_core
package npc_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    EXEC,
    WB,
    HALT
  } state_e;

  typedef enum logic [1:0] {
    TRAP_NONE     = 2'd0,
    TRAP_EBREAK   = 2'd1,
    TRAP_ILLEGAL  = 2'd2,
    TRAP_MISALIGN = 2'd3
  } trap_e;

endpackage

// File: rtl/npc_regfile.sv
// rtl/npc_regfile.sv - architectural register file, x0 hard zero, two async reads, one sync write
module npc_regfile #(
  parameter int XLEN    = 64,
  parameter int NR_REGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  localparam int AW = (NR_REGS == 16) ? 4 : 5;

  logic [XLEN-1:0] regs_q [NR_REGS];
  logic [XLEN-1:0] regs_d [NR_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != 5'd0) && (int'(waddr) < NR_REGS)) begin
      regs_d[waddr[AW-1:0]] = wdata;
    end
  end

  // Out-of-range indices read as zero; the core traps on them before they matter.
  assign rdata1 = ((raddr1 == 5'd0) || (int'(raddr1) >= NR_REGS)) ? '0 : regs_q[raddr1[AW-1:0]];
  assign rdata2 = ((raddr2 == 5'd0) || (int'(raddr2) >= NR_REGS)) ? '0 : regs_q[raddr2[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/npc_mc_core.sv
// rtl/npc_mc_core.sv - multi-cycle RV32/RV64 (I/E) subset core with imem handshake and commit trace
module npc_mc_core
  import npc_pkg::*;
#(
  parameter int          XLEN     = 64,
  parameter int          NR_REGS  = 32,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [XLEN-1:0] pc,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic [31:0]     commit_inst,
  output logic            halted,
  output logic [1:0]      trap_cause,
  output logic [XLEN-1:0] halt_code
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] dnpc_q, dnpc_d;
  logic [4:0]      rd_q, rd_d;
  logic            req_valid_q, req_valid_d;
  logic            commit_valid_q, commit_valid_d;
  logic [XLEN-1:0] commit_pc_q, commit_pc_d;
  logic [31:0]     commit_inst_q, commit_inst_d;
  logic            halted_q, halted_d;
  trap_e           trap_q, trap_d;
  logic [XLEN-1:0] halt_code_q, halt_code_d;

  logic [XLEN-1:0] rs1_val, x10_val;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd_idx, rs1_idx;
  logic            rd_ok, rs1_ok;
  logic [XLEN-1:0] imm_i, imm_u, imm_j, pc_plus4;
  logic [XLEN-1:0] ex_res, ex_target;
  logic            ex_jump;
  trap_e           ex_cause;

  assign opcode   = inst_q[6:0];
  assign rd_idx   = inst_q[11:7];
  assign funct3   = inst_q[14:12];
  assign rs1_idx  = inst_q[19:15];
  assign rd_ok    = int'(rd_idx) < NR_REGS;
  assign rs1_ok   = int'(rs1_idx) < NR_REGS;
  assign imm_i    = XLEN'($signed(inst_q[31:20]));
  assign imm_u    = XLEN'($signed({inst_q[31:12], 12'b0}));
  assign imm_j    = XLEN'($signed({inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0}));
  assign pc_plus4 = pc_q + XLEN'(4);

  // Port 2 is dedicated to x10 so ebreak can report its exit code.
  npc_regfile #(
    .XLEN    (XLEN),
    .NR_REGS (NR_REGS)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs1_idx),
    .rdata1 (rs1_val),
    .raddr2 (5'd10),
    .rdata2 (x10_val),
    .we     (state_q == WB),
    .waddr  (rd_q),
    .wdata  (res_q)
  );

  always_comb begin
    ex_cause  = TRAP_NONE;
    ex_res    = '0;
    ex_target = pc_plus4;
    ex_jump   = 1'b0;
    case (opcode)
      OP_LUI: begin
        ex_res = imm_u;
        if (!rd_ok) ex_cause = TRAP_ILLEGAL;
      end
      OP_AUIPC: begin
        ex_res = pc_q + imm_u;
        if (!rd_ok) ex_cause = TRAP_ILLEGAL;
      end
      OP_OPIMM: begin
        ex_res = rs1_val + imm_i;
        if ((funct3 != F3_ADDI) || !rd_ok || !rs1_ok) ex_cause = TRAP_ILLEGAL;
      end
      OP_JAL: begin
        ex_res    = pc_plus4;
        ex_target = pc_q + imm_j;
        ex_jump   = 1'b1;
        if (!rd_ok) ex_cause = TRAP_ILLEGAL;
      end
      OP_JALR: begin
        ex_res    = pc_plus4;
        ex_target = (rs1_val + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
        ex_jump   = 1'b1;
        if ((funct3 != F3_JALR) || !rd_ok || !rs1_ok) ex_cause = TRAP_ILLEGAL;
      end
      OP_SYSTEM: begin
        ex_cause = (inst_q == EBREAK_WORD) ? TRAP_EBREAK : TRAP_ILLEGAL;
      end
      default: ex_cause = TRAP_ILLEGAL;
    endcase
    if ((ex_cause == TRAP_NONE) && ex_jump && ex_target[1]) begin
      ex_cause = TRAP_MISALIGN;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    res_d          = res_q;
    dnpc_d         = dnpc_q;
    rd_d           = rd_q;
    req_valid_d    = 1'b0;
    commit_valid_d = 1'b0;
    commit_pc_d    = commit_pc_q;
    commit_inst_d  = commit_inst_q;
    halted_d       = halted_q;
    trap_d         = trap_q;
    halt_code_d    = halt_code_q;
    case (state_q)
      FETCH: begin
        if (req_valid_q && imem_req_ready) state_d = WAIT;
        else req_valid_d = 1'b1;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Outputs are registered, so the commit pulse lands in WB (or the first HALT cycle for ebreak).
        if ((ex_cause == TRAP_NONE) || (ex_cause == TRAP_EBREAK)) begin
          commit_valid_d = 1'b1;
          commit_pc_d    = pc_q;
          commit_inst_d  = inst_q;
        end
        if (ex_cause == TRAP_NONE) begin
          res_d   = ex_res;
          dnpc_d  = ex_target;
          rd_d    = rd_idx;
          state_d = WB;
        end else begin
          state_d     = HALT;
          halted_d    = 1'b1;
          trap_d      = ex_cause;
          halt_code_d = (ex_cause == TRAP_EBREAK) ? x10_val : '0;
        end
      end
      WB: begin
        pc_d        = dnpc_q;
        state_d     = FETCH;
        req_valid_d = 1'b1;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC[XLEN-1:0];
      inst_q         <= '0;
      res_q          <= '0;
      dnpc_q         <= '0;
      rd_q           <= '0;
      req_valid_q    <= 1'b0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      commit_inst_q  <= '0;
      halted_q       <= 1'b0;
      trap_q         <= TRAP_NONE;
      halt_code_q    <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      inst_q         <= inst_d;
      res_q          <= res_d;
      dnpc_q         <= dnpc_d;
      rd_q           <= rd_d;
      req_valid_q    <= req_valid_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      commit_inst_q  <= commit_inst_d;
      halted_q       <= halted_d;
      trap_q         <= trap_d;
      halt_code_q    <= halt_code_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign commit_valid   = commit_valid_q;
  assign commit_pc      = commit_pc_q;
  assign commit_inst    = commit_inst_q;
  assign halted         = halted_q;
  assign trap_cause     = trap_q;
  assign halt_code      = halt_code_q;

endmodule
